// File: rtl/task_out_pkg.sv
// rtl/task_out_pkg.sv - shared types and sizing helpers for the task output packetizer
package task_out_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CLOSE = 2'd1,
    SEND  = 2'd2
  } state_t;

  function automatic int packet_beats(input int words, input int ratio);
    return words * ratio;
  endfunction

  function automatic int packet_bytes(input int words, input int in_width);
    return (words * in_width) / 8;
  endfunction

endpackage

// File: rtl/task_out_buffer.sv
// rtl/task_out_buffer.sv - packet word store, one write port, combinational read
module task_out_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 81,
  parameter int AW    = 7
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/task_out_packetizer.sv
// rtl/task_out_packetizer.sv - collects result words into a packet and streams it out as beats
module task_out_packetizer
  import task_out_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int MAX_WORDS  = 81,
  parameter int SIZE_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [IN_WIDTH-1:0]   i_data,
  input  logic                  i_data_valid,
  input  logic                  i_input_last,
  output logic                  o_in_ready,
  input  logic                  i_tmanager_ready,
  output logic                  o_tanswer_ready,
  output logic [OUT_WIDTH-1:0]  o_tdata,
  output logic                  o_tanswer_data_last,
  output logic [SIZE_WIDTH-1:0] o_packet_size_in_bytes,
  output logic                  o_busy,
  output logic                  o_full,
  output logic                  o_overflow
);

  localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W  = $clog2(MAX_WORDS + 1);
  localparam int AW     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  state_t               state, nxt_state;
  logic [CNT_W-1:0]     count, rd_idx, nxt_idx;
  logic [LANE_W-1:0]    lane, nxt_lane;
  logic [IN_WIDTH-1:0]  rd_word;
  logic [OUT_WIDTH-1:0] nxt_beat;
  logic                 wr_en, xfer, lane_wrap, nxt_final;

  assign o_in_ready = (state == LOAD);
  assign wr_en      = o_in_ready && i_data_valid;
  assign xfer       = o_tanswer_ready && i_tmanager_ready;
  assign lane_wrap  = (lane == LANE_W'(RATIO - 1));

  task_out_buffer #(
    .WIDTH (IN_WIDTH),
    .DEPTH (MAX_WORDS),
    .AW    (AW)
  ) u_buffer (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_waddr (count[AW-1:0]),
    .i_wdata (i_data),
    .i_raddr (nxt_idx[AW-1:0]),
    .o_rdata (rd_word)
  );

  // Position of the beat to present next: beat 0 when closing, else one past the current beat.
  always_comb begin
    nxt_idx  = rd_idx;
    nxt_lane = lane;
    if (state == CLOSE) begin
      nxt_idx  = '0;
      nxt_lane = '0;
    end else if (lane_wrap) begin
      nxt_idx  = rd_idx + 1'b1;
      nxt_lane = '0;
    end else begin
      nxt_lane = lane + 1'b1;
    end
    nxt_final = (nxt_idx == count - 1'b1) && (nxt_lane == LANE_W'(RATIO - 1));
    nxt_beat  = OUT_WIDTH'(rd_word >> (int'(nxt_lane) * OUT_WIDTH));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= LOAD;
    else       state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    unique case (state)
      LOAD: begin
        if (i_data_valid) begin
          if (i_input_last || count == CNT_W'(MAX_WORDS - 1)) nxt_state = CLOSE;
        end else if (i_input_last && count != '0) begin
          nxt_state = CLOSE;
        end
      end
      CLOSE:   nxt_state = SEND;
      SEND:    if (xfer && o_tanswer_data_last) nxt_state = LOAD;
      default: nxt_state = LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count                  <= '0;
      rd_idx                 <= '0;
      lane                   <= '0;
      o_tanswer_ready        <= 1'b0;
      o_tdata                <= '0;
      o_tanswer_data_last    <= 1'b0;
      o_packet_size_in_bytes <= '0;
      o_busy                 <= 1'b0;
      o_full                 <= 1'b0;
      o_overflow             <= 1'b0;
    end else begin
      o_overflow <= i_data_valid && !o_in_ready;
      case (state)
        LOAD: begin
          if (wr_en) count <= count + 1'b1;
          if (nxt_state == CLOSE) begin
            o_busy <= 1'b1;
            o_full <= 1'b1;
          end
        end
        CLOSE: begin
          o_tanswer_ready        <= 1'b1;
          o_tdata                <= nxt_beat;
          o_tanswer_data_last    <= (packet_beats(int'(count), RATIO) == 1);
          o_packet_size_in_bytes <= SIZE_WIDTH'(packet_bytes(int'(count), IN_WIDTH));
          rd_idx                 <= nxt_idx;
          lane                   <= nxt_lane;
        end
        SEND: begin
          if (xfer) begin
            if (o_tanswer_data_last) begin
              o_tanswer_ready        <= 1'b0;
              o_tanswer_data_last    <= 1'b0;
              o_packet_size_in_bytes <= '0;
              o_busy                 <= 1'b0;
              o_full                 <= 1'b0;
              count                  <= '0;
              rd_idx                 <= '0;
              lane                   <= '0;
            end else begin
              o_tdata             <= nxt_beat;
              o_tanswer_data_last <= nxt_final;
              rd_idx              <= nxt_idx;
              lane                <= nxt_lane;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/task_out_packetizer.md
# task_out_packetizer

Packet buffer and serializer between a task's result logic and the task manager's answer channel. Collects a variable-length packet of IN_WIDTH-bit words. Closes the packet on a word-count limit or on an explicit last marker. Streams it out as OUT_WIDTH-bit beats under a valid/ready handshake, with an exact byte count and a last-beat flag. It generalises the fixed-length, 8-bit, full-only output stage to configurable widths, short packets, backpressure-safe output and overflow reporting.

## Interface

Parameters:
- IN_WIDTH, 8, input word width; integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, output beat width; multiple of 8.
- MAX_WORDS, 81, maximum input words per packet (buffer depth).
- SIZE_WIDTH, 12, width of byte-count output; MAX_WORDS*IN_WIDTH/8 must be < 2**SIZE_WIDTH.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  reset; synchronous, active-high.
- i_data  in  IN_WIDTH  result word.
- i_data_valid  in  1  i_data is written this cycle.
- i_input_last  in  1  close the current packet.
- o_in_ready  out  1  block is accepting words (state LOAD).
- i_tmanager_ready  in  1  manager accepts the current beat.
- o_tanswer_ready  out  1  beat valid on o_tdata.
- o_tdata  out  OUT_WIDTH  output beat.
- o_tanswer_data_last  out  1  current beat is the final beat of the packet.
- o_packet_size_in_bytes  out  SIZE_WIDTH  byte length of the packet being sent; 0 otherwise.
- o_busy  out  1  packet closed or being sent.
- o_full  out  1  buffer holds a closed packet (CLOSE or SEND).
- o_overflow  out  1  one-cycle pulse: an input word was dropped.

## Operation

- RATIO = IN_WIDTH/OUT_WIDTH; a packet of N words produces N*RATIO beats.
- Size = N*IN_WIDTH/8.
- FSM states are LOAD, CLOSE and SEND. Reset enters LOAD.
- **LOAD:** each i_data_valid writes i_data at word index `count`, then count++.
  - Close → CLOSE when the write makes count == MAX_WORDS, or when i_data_valid && i_input_last (that word is included).
  - i_input_last without valid also closes if count > 0.
  - i_input_last without valid and count == 0 is ignored.
  - A limit close and a last close in the same cycle give a single close.
- **CLOSE (1 cycle):**
  - Latch size = count*IN_WIDTH/8.
  - Load o_tdata with beat 0.
  - Go to SEND.
- **SEND:**
  - A beat transfers on o_tanswer_ready && i_tmanager_ready.
  - On transfer, o_tdata loads the next beat.
  - Beat order: word 0 first; within a word, the least-significant OUT_WIDTH slice first.
  - o_tanswer_data_last is high exactly while the final beat is presented.
  - On transfer of the final beat: go to LOAD, clear count, word index and lane.
- **Overflow:** i_data_valid in CLOSE or SEND drops the word and pulses o_overflow the next cycle. The packet in flight is unaffected. i_input_last is ignored outside LOAD.
- **Reset mid-operation:** any packet is abandoned and its data discarded. All outputs return to reset values.

## Timing

- Reset values: o_tanswer_ready 0, o_tdata 0, o_tanswer_data_last 0, o_packet_size_in_bytes 0, o_busy 0, o_full 0, o_overflow 0.
- o_in_ready = (state == LOAD), so it is 1 after reset.
- All outputs are registered, except o_in_ready, which is decoded from the state register.
- **Closing edge E0** (the edge that accepts the closing word/last):
  - During the following cycle: CLOSE, o_busy = o_full = 1, o_in_ready = 0.
  - At E0+1: o_tanswer_ready = 1, o_tdata = beat 0, size valid, o_tanswer_data_last = (total beats == 1).
- **Handshake:** o_tdata, o_tanswer_data_last and size stay stable while o_tanswer_ready && !i_tmanager_ready.
  - With i_tmanager_ready held high, one beat transfers per cycle.
- **Final-beat transfer edge:** these outputs clear at that edge: o_tanswer_ready, o_tanswer_data_last, size, o_busy, o_full.
  - o_in_ready = 1 in the next cycle; a new word is accepted there.
- Minimum packet turnaround: 2 cycles after the close before the first beat.

## Structure

- Package task_out_pkg holds:
  - the state enum typedef (LOAD, CLOSE, SEND);
  - a localparam function computing beats and bytes from the word count.
- Sub-module task_out_buffer:
  - MAX_WORDS × IN_WIDTH register array or distributed RAM;
  - one write port, combinational read by word index.
  - The packetizer does the lane selection into the o_tdata register.
- Counter widths: $clog2(MAX_WORDS+1) for the word count, $clog2(RATIO) for the lane (min 1).

## Test plan

1. **Full packet at defaults.** Write bytes 0..80 with no last. Expect: close on the 81st write; 81 beats 0x00..0x50; last on 0x50; size 81; o_in_ready back to 1.
2. **Short packet.** Write 5 bytes A0..A4, last with A4. Expect: size 5; beats A0..A4; last on A4. A following i_input_last alone with an empty buffer produces no packet.
3. **Width conversion** (IN_WIDTH=32, OUT_WIDTH=8, MAX_WORDS=4). Write 0x03020100, then 0x07060504 with last. Expect: 8 beats 00..07; size 8; last on 07.
4. **Backpressure.** i_tmanager_ready follows the pattern 1,0,0,1,0,1… during test 1. Expect: each beat held stable while not ready; sequence intact; no duplicates or losses.
5. **Overflow.** Assert i_data_valid with 0xFF during SEND. Expect: o_overflow pulses once per dropped word; output beats unchanged; 0xFF absent from the next packet.
6. **Reset mid-SEND.** Assert i_rst after 3 beats. Expect: next cycle all outputs at reset values. A subsequent 2-byte packet 11,22 with last sends size 2, beats 11,22.
